// File: rtl/bypass_reg_file.sv
// ----------------------------------------------------------------------------
// bypass_reg_file
//
// General-purpose register bank feeding the ALU operand muxes. Holds DEPTH
// entries of WIDTH bits with one synchronous write port and two independent
// combinational read ports. Both read ports see a same-cycle write through a
// bypass path. Each entry carries a valid bit that is set by a write and
// cleared by reset or by the bulk-clear engine. The clear engine wipes one
// entry per clock, so a full clear takes exactly DEPTH cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst_b      asynchronous reset, active-high (1 = reset asserted)
//   we         write enable
//   waddr      write address
//   wdata      write data
//   ra_addr    read port A address
//   ra_data    read port A data (combinational, bypassed)
//   ra_valid   read port A entry valid
//   rb_addr    read port B address
//   rb_data    read port B data (combinational, bypassed)
//   rb_valid   read port B entry valid
//   clr_start  request a bulk clear (pulse or level)
//   clr_busy   clear sequence in progress
//   clr_done   one-cycle pulse when the clear has finished
//   wr_drop    one-cycle pulse the cycle after a write was discarded
// ----------------------------------------------------------------------------
module bypass_reg_file #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    ra_addr,
    output logic [WIDTH-1:0] ra_data,
    output logic             ra_valid,
    input  logic [AW-1:0]    rb_addr,
    output logic [WIDTH-1:0] rb_data,
    output logic             rb_valid,
    input  logic             clr_start,
    output logic             clr_busy,
    output logic             clr_done,
    output logic             wr_drop
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // One extra bit so the range check also works when DEPTH == 2**AW.
    localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [1:0]       state;
    logic [AW-1:0]    ptr;

    logic waddr_ok;
    logic ra_ok;
    logic rb_ok;
    logic wr_ok;

    assign waddr_ok = ({1'b0, waddr}   < DEPTH_EXT);
    assign ra_ok    = ({1'b0, ra_addr} < DEPTH_EXT);
    assign rb_ok    = ({1'b0, rb_addr} < DEPTH_EXT);

    // A write is only committed outside the clear sequence and to an
    // existing entry; anything else is dropped and flagged next cycle.
    assign wr_ok = we && (state != CLEAR) && waddr_ok;

    // Storage, valid bits, clear sequencer and the drop flag.
    // The clear engine and the write port never touch storage in the same
    // cycle because writes are refused while the sequencer is in CLEAR.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            valid   <= '0;
            state   <= IDLE;
            ptr     <= '0;
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= we && !wr_ok;

            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state <= CLEAR;
                        ptr   <= '0;
                    end
                end
                CLEAR: begin
                    mem[ptr]   <= '0;
                    valid[ptr] <= 1'b0;
                    if (ptr == PTR_LAST) begin
                        state <= DONE;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (wr_ok) begin
                mem[waddr]   <= wdata;
                valid[waddr] <= 1'b1;
            end
        end
    end

    // Read port A: a committed same-cycle write wins over storage; an
    // out-of-range address reads as an empty, invalid entry.
    always_comb begin
        ra_data  = '0;
        ra_valid = 1'b0;
        if (wr_ok && (waddr == ra_addr)) begin
            ra_data  = wdata;
            ra_valid = 1'b1;
        end else if (ra_ok) begin
            ra_data  = mem[ra_addr];
            ra_valid = valid[ra_addr];
        end
    end

    // Read port B: identical to port A.
    always_comb begin
        rb_data  = '0;
        rb_valid = 1'b0;
        if (wr_ok && (waddr == rb_addr)) begin
            rb_data  = wdata;
            rb_valid = 1'b1;
        end else if (rb_ok) begin
            rb_data  = mem[rb_addr];
            rb_valid = valid[rb_addr];
        end
    end

    // Handshake flags come straight from the state register.
    assign clr_busy = (state == CLEAR);
    assign clr_done = (state == DONE);

endmodule

// File: tb/tb_bypass_reg_file.sv
// ----------------------------------------------------------------------------
// tb_bypass_reg_file
//
// Drives two copies of bypass_reg_file with identical stimulus: one with the
// default 8 entries and one with 6 entries (so addresses 6 and 7 are out of
// range). A small behavioural model of the register bank predicts every
// output of both copies each cycle.
// ----------------------------------------------------------------------------
module tb_bypass_reg_file;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  ra_addr;
    logic [2:0]  rb_addr;
    logic        clr_start;

    logic [15:0] ra_data0, rb_data0, ra_data1, rb_data1;
    logic        ra_valid0, rb_valid0, ra_valid1, rb_valid1;
    logic        clr_busy0, clr_done0, wr_drop0;
    logic        clr_busy1, clr_done1, wr_drop1;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Behavioural model, one slot per DUT copy.
    int          depth [2] = '{8, 6};
    logic [15:0] m_mem   [2][8];
    bit          m_valid [2][8];
    bit          m_clearing [2];
    int          m_cleared  [2];
    bit          m_done     [2];
    bit          m_drop     [2];

    always #5 clk = ~clk;

    bypass_reg_file #(.WIDTH(16), .DEPTH(8), .AW(3)) dut0 (
        .clk(clk), .rst_b(rst_b), .we(we), .waddr(waddr), .wdata(wdata),
        .ra_addr(ra_addr), .ra_data(ra_data0), .ra_valid(ra_valid0),
        .rb_addr(rb_addr), .rb_data(rb_data0), .rb_valid(rb_valid0),
        .clr_start(clr_start), .clr_busy(clr_busy0), .clr_done(clr_done0),
        .wr_drop(wr_drop0)
    );

    bypass_reg_file #(.WIDTH(16), .DEPTH(6), .AW(3)) dut1 (
        .clk(clk), .rst_b(rst_b), .we(we), .waddr(waddr), .wdata(wdata),
        .ra_addr(ra_addr), .ra_data(ra_data1), .ra_valid(ra_valid1),
        .rb_addr(rb_addr), .rb_data(rb_data1), .rb_valid(rb_valid1),
        .clr_start(clr_start), .clr_busy(clr_busy1), .clr_done(clr_done1),
        .wr_drop(wr_drop1)
    );

    function automatic bit model_wr_ok(int k);
        return we && !m_clearing[k] && (int'(waddr) < depth[k]);
    endfunction

    function automatic logic [15:0] model_data(int k, logic [2:0] a);
        if (model_wr_ok(k) && waddr == a) return wdata;
        if (int'(a) < depth[k]) return m_mem[k][a];
        return 16'h0000;
    endfunction

    function automatic bit model_valid(int k, logic [2:0] a);
        if (model_wr_ok(k) && waddr == a) return 1'b1;
        if (int'(a) < depth[k]) return m_valid[k][a];
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                m_mem[k][i]   = 16'h0000;
                m_valid[k][i] = 1'b0;
            end
            m_clearing[k] = 1'b0;
            m_cleared[k]  = 0;
            m_done[k]     = 1'b0;
            m_drop[k]     = 1'b0;
        end
    endtask

    // Advance the model by one rising edge using the inputs now applied.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            bit ok;
            ok = model_wr_ok(k);
            if (m_clearing[k]) begin
                m_mem[k][m_cleared[k]]   = 16'h0000;
                m_valid[k][m_cleared[k]] = 1'b0;
                m_cleared[k]++;
                if (m_cleared[k] == depth[k]) begin
                    m_clearing[k] = 1'b0;
                    m_done[k]     = 1'b1;
                end
            end else if (m_done[k]) begin
                m_done[k] = 1'b0;
            end else if (clr_start) begin
                m_clearing[k] = 1'b1;
                m_cleared[k]  = 0;
            end
            if (ok) begin
                m_mem[k][waddr]   = wdata;
                m_valid[k][waddr] = 1'b1;
            end
            m_drop[k] = we && !ok;
        end
    endtask

    task automatic chk(string tag, logic [31:0] observed, logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_inst(int k, logic [15:0] rad, logic rav, logic [15:0] rbd,
                              logic rbv, logic busy, logic done, logic drop);
        chk($sformatf("d%0d.ra_data@%0d", k, ra_addr), 32'(rad), 32'(model_data(k, ra_addr)));
        chk($sformatf("d%0d.ra_valid@%0d", k, ra_addr), 32'(rav), 32'(model_valid(k, ra_addr)));
        chk($sformatf("d%0d.rb_data@%0d", k, rb_addr), 32'(rbd), 32'(model_data(k, rb_addr)));
        chk($sformatf("d%0d.rb_valid@%0d", k, rb_addr), 32'(rbv), 32'(model_valid(k, rb_addr)));
        chk($sformatf("d%0d.clr_busy", k), 32'(busy), 32'(m_clearing[k]));
        chk($sformatf("d%0d.clr_done", k), 32'(done), 32'(m_done[k]));
        chk($sformatf("d%0d.wr_drop", k), 32'(drop), 32'(m_drop[k]));
    endtask

    task automatic checkOutput();
        #1;
        check_inst(0, ra_data0, ra_valid0, rb_data0, rb_valid0, clr_busy0, clr_done0, wr_drop0);
        check_inst(1, ra_data1, ra_valid1, rb_data1, rb_valid1, clr_busy1, clr_done1, wr_drop1);
    endtask

    // Commit the current inputs with one rising edge, then return at the
    // following falling edge where the next inputs are driven.
    task automatic applyStimulus();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic read_all();
        for (int a = 0; a < 8; a++) begin
            ra_addr = 3'(a);
            rb_addr = 3'(7 - a);
            checkOutput();
        end
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;

        rst_b = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        ra_addr = '0; rb_addr = '0; clr_start = 1'b0;
        model_reset();

        // Reset state: every address empty and invalid.
        @(negedge clk);
        @(negedge clk);
        read_all();
        rst_b = 1'b0;
        checkOutput();

        // Same-cycle bypass, then the stored value on both ports.
        we = 1'b1; waddr = 3'd3; wdata = 16'hA5A5; ra_addr = 3'd3; rb_addr = 3'd0;
        checkOutput();
        applyStimulus();
        we = 1'b0; rb_addr = 3'd3;
        checkOutput();
        applyStimulus();

        // Fill the bank, then run a bulk clear with a write attempted mid-clear.
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; waddr = 3'(i); wdata = 16'h1000 + 16'(i);
            checkOutput();
            applyStimulus();
        end
        we = 1'b0; clr_start = 1'b1; ra_addr = 3'd2; rb_addr = 3'd7;
        checkOutput();
        applyStimulus();
        clr_start = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 20 && done_cnt == 0; c++) begin
            we = (c == 2); waddr = 3'd2; wdata = 16'hBEEF;
            checkOutput();
            if (clr_busy0) busy_cnt++;
            if (clr_done0) done_cnt++;
            applyStimulus();
        end
        chk("clear_busy_cycles", 32'(busy_cnt), 32'd8);
        chk("clear_done_seen", 32'(done_cnt), 32'd1);
        we = 1'b0;
        read_all();

        // Address 7 is valid on the 8-entry copy and out of range on the 6-entry one.
        we = 1'b1; waddr = 3'd7; wdata = 16'h1234; ra_addr = 3'd7; rb_addr = 3'd5;
        checkOutput();
        applyStimulus();
        we = 1'b0;
        checkOutput();
        applyStimulus();
        checkOutput();

        // Reset in the middle of a clear, then a complete clear afterwards.
        we = 1'b1; waddr = 3'd1; wdata = 16'h7777; clr_start = 1'b1;
        checkOutput();
        applyStimulus();
        we = 1'b0; clr_start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checkOutput();
            applyStimulus();
        end
        rst_b = 1'b1;
        #1;
        model_reset();
        checkOutput();
        chk("midclear_reset_busy", 32'(clr_busy0), 32'd0);
        read_all();
        rst_b = 1'b0;
        applyStimulus();
        clr_start = 1'b1;
        checkOutput();
        applyStimulus();
        clr_start = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 20 && done_cnt == 0; c++) begin
            checkOutput();
            if (clr_busy0) busy_cnt++;
            if (clr_done0) done_cnt++;
            applyStimulus();
        end
        chk("reclear_busy_cycles", 32'(busy_cnt), 32'd8);
        chk("reclear_done_seen", 32'(done_cnt), 32'd1);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            we        = 1'($urandom_range(0, 1));
            waddr     = 3'($urandom_range(0, 7));
            wdata     = 16'($urandom);
            ra_addr   = 3'($urandom_range(0, 7));
            rb_addr   = ($urandom_range(0, 3) == 0) ? ra_addr : 3'($urandom_range(0, 7));
            clr_start = ($urandom_range(0, 15) == 0);
            checkOutput();
            applyStimulus();
        end
        we = 1'b0; clr_start = 1'b0;
        checkOutput();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
